// File: rtl/uart_pkg.sv
// Shared UART constants: receiver byte width and default receive FIFO depth.
package uart_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int RX_FIFO_DEPTH = 8;

   // Width of an occupancy counter able to hold 0..depth inclusive
   function automatic int fifo_count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rx_fifo_rise_detect.sv
// Registered 0->1 detector. The history register resets to 1 so that a level
// already high when reset is released does not look like a new rising edge.
module rise_detect (
   input  logic clk16,
   input  logic rst,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;

   // Remember the level seen at the previous clock edge
   always_ff @(posedge clk16) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level_i;
      end
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/rx_fifo.sv
// Receive byte FIFO. Each rising edge of rx_done stores one byte; rd_en pops
// one byte per cycle into a registered rd_data with a one-cycle rd_valid.
// A byte arriving while full (and no read in the same cycle) is dropped and
// raises a sticky overflow flag.
module rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH,
   parameter int WIDTH = UART_DATA_W
) (
   input  logic                     clk16,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         rx_data,
   input  logic                     rx_done,
   input  logic                     rd_en,
   input  logic                     clr_ovf,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = fifo_count_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;
   logic             overflow_q, overflow_d;

   logic wr_event;
   logic do_rd;
   logic do_wr;
   logic drop;

   rise_detect u_rise (
      .clk16   (clk16),
      .rst     (rst),
      .level_i (rx_done),
      .rise_o  (wr_event)
   );

   // A read frees a slot before the write lands, so a full FIFO accepts a
   // write when a read happens in the same cycle.
   assign do_rd = rd_en && (count_q != '0);
   assign do_wr = wr_event && ((count_q != FULL_CNT) || do_rd);
   assign drop  = wr_event && !do_wr;

   // Next-state for pointers, occupancy and the sticky overflow flag
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_wr && !do_rd) count_d = count_q + CW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CW'(1);
      // A new drop wins over a coincident clear
      if (drop) overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   // Control and output registers
   always_ff @(posedge clk16) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= do_rd;
         overflow_q <= overflow_d;
         if (do_rd) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Storage array; contents are unreadable until rewritten, so no reset
   always_ff @(posedge clk16) begin
      if (do_wr && !rst) mem_q[wr_ptr_q] <= rx_data;
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);

endmodule

// File: tb/tb_rx_fifo.sv
// Scoreboard bench for rx_fifo: expected bytes are queued as they are
// written; a monitor pops and compares on every rd_valid strobe.
module tb_rx_fifo;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;

   logic             clk16 = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] rx_data;
   logic             rx_done;
   logic             rd_en;
   logic             clr_ovf;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             empty;
   logic             full;
   logic [3:0]       count;
   logic             overflow;

   int vectors    = 0;
   int miscompares = 0;
   logic [WIDTH-1:0] exp_q [$];

   rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk16    (clk16),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .rd_en    (rd_en),
      .clr_ovf  (clr_ovf),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk16 = ~clk16;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Monitor: every rd_valid strobe must match the oldest expected byte
   always @(negedge clk16) begin
      if (rd_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: got rd_data %0h, required no rd_valid", rd_data);
         end else begin
            automatic logic [WIDTH-1:0] e = exp_q.pop_front();
            if (rd_data !== e) begin
               miscompares++;
               $display("FAIL rd_data: got %0h, required %0h", rd_data, e);
            end else begin
               $display("ok   rd_data: %0h", rd_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk16);
      #1;
   endtask

   // Raise rx_done for 'hold' cycles then drop it for one cycle
   task automatic write_byte(input logic [WIDTH-1:0] b, input int hold);
      rx_data = b;
      rx_done = 1'b1;
      repeat (hold) tick();
      rx_done = 1'b0;
      tick();
   endtask

   task automatic rd_pulse();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_data = '0; rx_done = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
      repeat (3) tick();
      check("reset_count", count, 0);
      check("reset_empty", empty, 1);
      check("reset_full", full, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_overflow", overflow, 0);
      check("reset_rd_data", rd_data, 0);

      // rx_done already high at reset release creates no write
      rst = 1'b0;
      repeat (5) tick();
      check("held_high_count", count, 0);
      check("held_high_empty", empty, 1);
      rx_done = 1'b0;
      tick();

      // Two long-held bytes, each written exactly once
      exp_q.push_back(8'h55); write_byte(8'h55, 20);
      exp_q.push_back(8'hA3); write_byte(8'hA3, 20);
      check("two_writes_count", count, 2);
      rd_pulse();
      rd_pulse();
      tick();
      check("two_reads_empty", empty, 1);
      tick();
      check("rd_data_hold", rd_data, 8'hA3);

      // Nine writes into eight slots: last one dropped
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) exp_q.push_back(8'(i));
         write_byte(8'(i), 2);
         if (i == 8) check("fill_overflow_clear", overflow, 0);
      end
      check("overfill_full", full, 1);
      check("overfill_count", count, 8);
      check("overfill_overflow", overflow, 1);
      for (int i = 0; i < 8; i++) rd_pulse();
      tick();
      check("drain_empty", empty, 1);
      check("overflow_sticky", overflow, 1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("clr_ovf", overflow, 0);

      // Drop coincident with clear leaves overflow set
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(8'(8'h10 + i));
         write_byte(8'(8'h10 + i), 1);
      end
      rx_data = 8'h99; rx_done = 1'b1; clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0; rx_done = 1'b0;
      check("drop_beats_clear", overflow, 1);
      tick();
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("clr_after_drop", overflow, 0);

      // Full: write and read in the same cycle, no overflow
      exp_q.push_back(8'h77);
      rx_data = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0; rx_done = 1'b0;
      tick();
      check("full_rw_overflow", overflow, 0);
      check("full_rw_count", count, 8);
      for (int i = 0; i < 8; i++) rd_pulse();
      tick();
      check("full_rw_drained", empty, 1);

      // Reads on empty are ignored
      rd_en = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      check("empty_read_count", count, 0);
      check("empty_read_valid", rd_valid, 0);

      // Write and read together while empty: write only
      exp_q.push_back(8'hC1);
      rx_data = 8'hC1; rx_done = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0; rx_done = 1'b0;
      check("empty_rw_valid", rd_valid, 0);
      check("empty_rw_count", count, 1);
      tick();
      // Write and read together with one stored: count unchanged
      exp_q.push_back(8'hC2);
      rx_data = 8'hC2; rx_done = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0; rx_done = 1'b0;
      check("mid_rw_count", count, 1);
      tick();
      rd_pulse();
      tick();

      // Twelve write/read pairs walk the pointers past the wrap
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(8'(8'hA0 + i));
         write_byte(8'(8'hA0 + i), 1);
         rd_pulse();
      end
      tick();
      check("wrap_empty", empty, 1);

      // Reset with five entries stored discards them
      for (int i = 0; i < 5; i++) write_byte(8'(8'hE0 + i), 1);
      check("pre_reset_count", count, 5);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_reset_count", count, 0);
      check("mid_reset_empty", empty, 1);
      rd_pulse();
      check("post_reset_read_valid", rd_valid, 0);
      tick();
      tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
